pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage LC-3b pipeline. Each cycle it decides which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) load, hold, or take a NOP bubble. Inputs are instruction/data memory handshakes, load-use hazards and control transfers resolved in MEM. A small FSM sequences data-memory waits, including the two-access LDI/STI indirect sequence.

---
 rtl/lc3b_types.sv | 18 +
 rtl/pipeline_ctrl_hazard_detect.sv | 23 ++
 rtl/pipeline_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: control FSM states, register index, NOP and
// counter widths.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    D1  = 2'd1,
    D2  = 2'd2
  } lc3b_pipe_state;

  localparam logic [15:0] LC3B_NOP = 16'h0000;

  localparam int PERF_STALL_W = 32;
  localparam int PERF_REDIR_W = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
// Kept separate so the forwarding unit can share the same compare.
module hazard_detect
  import lc3b_types::*;
(
  input  logic    ex_mem_read,
  input  logic    ex_regwrite,
  input  lc3b_reg ex_dest,
  input  lc3b_reg id_sr1,
  input  lc3b_reg id_sr2,
  input  logic    id_uses_sr1,
  input  logic    id_uses_sr2,
  output logic    load_use
);

  logic w_hit1;
  logic w_hit2;

  assign w_hit1   = id_uses_sr1 && (id_sr1 == ex_dest);
  assign w_hit2   = id_uses_sr2 && (id_sr2 == ex_dest);
  assign load_use = ex_mem_read && ex_regwrite && (w_hit1 || w_hit2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline.
// Optional perf counters: define PIPE_PERF_CTR_EN.
module pipeline_ctrl
  import lc3b_types::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    imem_resp,
  input  logic    dmem_req,
  input  logic    dmem_resp,
  input  logic    mem_indirect,
  input  logic    mem_br_taken,
  input  logic    ex_mem_read,
  input  logic    ex_regwrite,
  input  lc3b_reg ex_dest,
  input  lc3b_reg id_sr1,
  input  lc3b_reg id_sr2,
  input  logic    id_uses_sr1,
  input  logic    id_uses_sr2,
  output logic    load_pc,
  output logic    load_if_id,
  output logic    load_id_ex,
  output logic    load_ex_mem,
  output logic    load_mem_wb,
  output logic    flush_if_id,
  output logic    flush_id_ex,
  output logic    flush_ex_mem,
  output logic    dmem_phase,
  output logic    stall
`ifdef PIPE_PERF_CTR_EN
  ,
  output logic [PERF_STALL_W-1:0] perf_stall_cycles,
  output logic [PERF_REDIR_W-1:0] perf_redirects
`endif
);

  lc3b_pipe_state r_state;

  logic w_load_use;
  logic w_dmem_done;
  logic w_run_to_d2;
  logic w_redir;

  hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_regwrite (ex_regwrite),
    .ex_dest     (ex_dest),
    .id_sr1      (id_sr1),
    .id_sr2      (id_sr2),
    .id_uses_sr1 (id_uses_sr1),
    .id_uses_sr2 (id_uses_sr2),
    .load_use    (w_load_use)
  );

  assign w_run_to_d2 = (r_state == RUN) && dmem_req
                    && dmem_resp && mem_indirect;

  always_comb begin
    w_dmem_done = 1'b0;
    unique case (r_state)
      RUN:     w_dmem_done = !dmem_req || (dmem_resp && !mem_indirect);
      D1:      w_dmem_done = dmem_resp && !mem_indirect;
      D2:      w_dmem_done = dmem_resp;
      default: w_dmem_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      unique case (r_state)
        RUN: begin
          if (dmem_req && !dmem_resp)
            r_state <= D1;
          else if (w_run_to_d2)
            r_state <= D2;
        end
        D1: begin
          if (dmem_resp)
            r_state <= mem_indirect ? D2 : RUN;
        end
        D2: begin
          if (dmem_resp)
            r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Priority: reset, data wait, redirect, load-use, fetch miss.
  always_comb begin
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    w_redir      = 1'b0;
    if (reset || !w_dmem_done) begin
      load_pc = 1'b0;
    end else if (mem_br_taken && !imem_resp) begin
      load_pc = 1'b0;
    end else if (mem_br_taken) begin
      w_redir      = 1'b1;
      load_pc      = 1'b1;
      load_if_id   = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (w_load_use) begin
      load_id_ex  = 1'b1;
      flush_id_ex = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
    end else if (!imem_resp) begin
      load_if_id  = 1'b1;
      flush_if_id = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
    end else begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
    end
  end

  assign dmem_phase = !reset && ((r_state == D2) || w_run_to_d2);
  assign stall      = !load_mem_wb;

`ifdef PIPE_PERF_CTR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (w_redir && (perf_redirects != '1))
        perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl.
// Output vector: {loads[5], flushes[3], dmem_phase, stall}.
module tb_pipeline_ctrl;
  import lc3b_types::*;

  logic    clk = 1'b0;
  logic    reset;
  logic    imem_resp;
  logic    dmem_req;
  logic    dmem_resp;
  logic    mem_indirect;
  logic    mem_br_taken;
  logic    ex_mem_read;
  logic    ex_regwrite;
  lc3b_reg ex_dest;
  lc3b_reg id_sr1;
  lc3b_reg id_sr2;
  logic    id_uses_sr1;
  logic    id_uses_sr2;
  logic    load_pc;
  logic    load_if_id;
  logic    load_id_ex;
  logic    load_ex_mem;
  logic    load_mem_wb;
  logic    flush_if_id;
  logic    flush_id_ex;
  logic    flush_ex_mem;
  logic    dmem_phase;
  logic    stall;
`ifdef PIPE_PERF_CTR_EN
  logic [PERF_STALL_W-1:0] perf_stall_cycles;
  logic [PERF_REDIR_W-1:0] perf_redirects;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];

  localparam logic [9:0] ALL1   = 10'b11111_000_0_0;
  localparam logic [9:0] FRZ    = 10'b00000_000_0_1;
  localparam logic [9:0] FRZ_P  = 10'b00000_000_1_1;
  localparam logic [9:0] GO_P   = 10'b11111_000_1_0;
  localparam logic [9:0] REDIR  = 10'b11111_111_0_0;
  localparam logic [9:0] BUBBLE = 10'b00111_010_0_0;
  localparam logic [9:0] IMISS  = 10'b01111_100_0_0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_resp    (dmem_resp),
    .mem_indirect (mem_indirect),
    .mem_br_taken (mem_br_taken),
    .ex_mem_read  (ex_mem_read),
    .ex_regwrite  (ex_regwrite),
    .ex_dest      (ex_dest),
    .id_sr1       (id_sr1),
    .id_sr2       (id_sr2),
    .id_uses_sr1  (id_uses_sr1),
    .id_uses_sr2  (id_uses_sr2),
    .load_pc      (load_pc),
    .load_if_id   (load_if_id),
    .load_id_ex   (load_id_ex),
    .load_ex_mem  (load_ex_mem),
    .load_mem_wb  (load_mem_wb),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_ex_mem (flush_ex_mem),
    .dmem_phase   (dmem_phase),
    .stall        (stall)
`ifdef PIPE_PERF_CTR_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  function automatic logic [9:0] obs();
    return {load_pc, load_if_id, load_id_ex, load_ex_mem,
            load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem,
            dmem_phase, stall};
  endfunction

  task automatic idle();
    reset        = 1'b0;
    imem_resp    = 1'b1;
    dmem_req     = 1'b0;
    dmem_resp    = 1'b0;
    mem_indirect = 1'b0;
    mem_br_taken = 1'b0;
    ex_mem_read  = 1'b0;
    ex_regwrite  = 1'b0;
    ex_dest      = 3'd0;
    id_sr1       = 3'd1;
    id_sr2       = 3'd2;
    id_uses_sr1  = 1'b0;
    id_uses_sr2  = 1'b0;
  endtask

  // Inputs are already driven; queue the expectation, compare on the
  // falling edge, then advance one clock.
  task automatic cyc(input logic [9:0] e, input string t);
    exp_t it;
    it.exp = e;
    it.tag = t;
    sb.push_back(it);
    @(negedge clk);
    it = sb.pop_front();
    checks++;
    assert (obs() === it.exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", it.tag, obs(), it.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset    = 1'b1;
    dmem_req = 1'b1;
    @(posedge clk);
    #1;
    cyc(FRZ, "reset0");
    cyc(FRZ, "reset1");
`ifdef PIPE_PERF_CTR_EN
    checks++;
    assert (perf_stall_cycles === 32'd0 && perf_redirects === 16'd0)
    else begin
      errors++;
      $error("FAIL perf_reset observed=%0d/%0d expected=0/0",
             perf_stall_cycles, perf_redirects);
    end
`endif
    idle();
    cyc(ALL1, "post_reset_run");

    // LDR with response three cycles later
    dmem_req = 1'b1;
    cyc(FRZ, "ldr_w0");
    cyc(FRZ, "ldr_w1");
    cyc(FRZ, "ldr_w2");
    dmem_resp = 1'b1;
    cyc(ALL1, "ldr_resp");
    idle();
    cyc(ALL1, "ldr_back_run");

    // Non-indirect access with same-cycle response
    dmem_req  = 1'b1;
    dmem_resp = 1'b1;
    cyc(ALL1, "ld_zero_stall");
    idle();

    // LDI, responses at cycles 2 and 4
    dmem_req     = 1'b1;
    mem_indirect = 1'b1;
    cyc(FRZ, "ldi_c1");
    dmem_resp = 1'b1;
    cyc(FRZ, "ldi_c2_resp1");
    dmem_resp = 1'b0;
    cyc(FRZ_P, "ldi_c3_phase1");
    dmem_resp = 1'b1;
    cyc(GO_P, "ldi_c4_resp2");
    idle();
    cyc(ALL1, "ldi_back_run");

    // STI with immediate first response
    dmem_req     = 1'b1;
    mem_indirect = 1'b1;
    dmem_resp    = 1'b1;
    cyc(FRZ_P, "sti_fast_c1");
    cyc(GO_P, "sti_fast_c2");
    idle();

    // Load-use on sr1, then not used, then sr2, then non-writing load
    ex_mem_read = 1'b1;
    ex_regwrite = 1'b1;
    ex_dest     = 3'd3;
    id_sr1      = 3'd3;
    id_uses_sr1 = 1'b1;
    cyc(BUBBLE, "lu_sr1");
    id_uses_sr1 = 1'b0;
    cyc(ALL1, "lu_sr1_unused");
    id_sr2      = 3'd3;
    id_uses_sr2 = 1'b1;
    cyc(BUBBLE, "lu_sr2");
    ex_regwrite = 1'b0;
    cyc(ALL1, "lu_no_regwrite");
    idle();

    // Fetch miss alone, and with load-use (load-use wins)
    imem_resp = 1'b0;
    cyc(IMISS, "imiss");
    ex_mem_read = 1'b1;
    ex_regwrite = 1'b1;
    ex_dest     = 3'd5;
    id_sr2      = 3'd5;
    id_uses_sr2 = 1'b1;
    cyc(BUBBLE, "imiss_vs_lu");
    idle();

    // Redirect waiting on fetch
    mem_br_taken = 1'b1;
    imem_resp    = 1'b0;
    cyc(FRZ, "br_wait0");
    cyc(FRZ, "br_wait1");
    imem_resp = 1'b1;
    cyc(REDIR, "br_go");
    idle();

    // Redirect beats load-use
    mem_br_taken = 1'b1;
    ex_mem_read  = 1'b1;
    ex_regwrite  = 1'b1;
    ex_dest      = 3'd4;
    id_sr1       = 3'd4;
    id_uses_sr1  = 1'b1;
    cyc(REDIR, "br_vs_lu");
    idle();

    // Data wait beats redirect
    dmem_req     = 1'b1;
    mem_br_taken = 1'b1;
    cyc(FRZ, "dmem_vs_br");
    dmem_resp = 1'b1;
    cyc(REDIR, "dmem_then_br");
    idle();
`ifdef PIPE_PERF_CTR_EN
    checks++;
    assert (perf_redirects === 16'd3) else begin
      errors++;
      $error("FAIL perf_redirects observed=%0d expected=3",
             perf_redirects);
    end
`endif

    // Reset in the middle of a D1 wait
    dmem_req = 1'b1;
    cyc(FRZ, "mid_d1");
    reset = 1'b1;
    cyc(FRZ, "mid_reset");
    idle();
    cyc(ALL1, "after_mid_reset");

    // Reset in D2 with dmem_phase forced low
    dmem_req     = 1'b1;
    mem_indirect = 1'b1;
    dmem_resp    = 1'b1;
    cyc(FRZ_P, "to_d2");
    reset = 1'b1;
    cyc(FRZ, "reset_in_d2");
    idle();
    cyc(ALL1, "after_d2_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
